// File: rtl/debug_ocimem_master_if.sv
// Avalon-MM single-word master bus between the OCI memory master and CPU memory.
interface debug_ocimem_master_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/debug_ocimem_master.sv
// Executes decoded JTAG OCI memory commands as single-word Avalon-MM transfers,
// auto-incrementing the word address and reporting results through MonDReg.
module debug_ocimem_master #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [37:0]                   jdo,
    input  logic                          take_action_ocimem_a,
    input  logic                          take_no_action_ocimem_a,
    input  logic                          take_action_ocimem_b,
    debug_ocimem_master_if.master         avm,
    output logic [31:0]                   MonDReg,
    output logic                          monitor_ready,
    output logic                          monitor_error,
    output logic                          cmd_overrun
);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mon_q, mon_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       tcount_q, tcount_d;

    logic start_rd, start_wr, any_strobe;

    // Address and write-data fields share jdo; only these bits carry nothing here.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        read_d    = read_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        mon_d     = mon_q;
        ready_d   = ready_q;
        error_d   = error_q;
        overrun_d = overrun_q;
        tcount_d  = tcount_q;
        start_rd  = 1'b0;
        start_wr  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (take_action_ocimem_a) begin
                    addr_d = jdo[ADDR_W+1:2];
                    if (jdo[35]) begin
                        error_d   = 1'b0;
                        overrun_d = 1'b0;
                    end
                    start_rd = jdo[34];
                end else if (take_action_ocimem_b) begin
                    start_wr = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    start_rd = 1'b1;
                end

                if (start_rd || start_wr) begin
                    ready_d  = 1'b0;
                    error_d  = 1'b0;
                    tcount_d = '0;
                end
                if (start_rd) begin
                    read_d  = 1'b1;
                    state_d = StRd;
                end
                if (start_wr) begin
                    write_d = 1'b1;
                    wdata_d = jdo[34:3];
                    state_d = StWr;
                end
            end

            StRd, StWr: begin
                if (any_strobe) begin
                    overrun_d = 1'b1;
                end
                if (!avm.avm_waitrequest) begin
                    mon_d   = (state_q == StRd) ? avm.avm_readdata : wdata_q;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    addr_d  = addr_q + ADDR_W'(1);
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    tcount_d = tcount_q + 16'd1;
                    // This stall cycle is the TIMEOUT-th one: abort without advancing addr.
                    if (tcount_q == 16'(TIMEOUT - 1)) begin
                        mon_d   = '0;
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        error_d = 1'b1;
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            mon_q     <= '0;
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
            tcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            mon_q     <= mon_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
            tcount_q  <= tcount_d;
        end
    end

    assign avm.avm_address    = {addr_q, 2'b00};
    assign avm.avm_read       = read_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = 4'hF;

    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign cmd_overrun   = overrun_q;

endmodule

// File: tb/tb_debug_ocimem_master.sv
// Directed bench for debug_ocimem_master; TIMEOUT is shortened to 4 stall cycles.
module tb_debug_ocimem_master;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_no, take_b;
    logic [31:0] mon;
    logic        ready, error, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    debug_ocimem_master_if #(.ADDR_W(10)) bus ();

    debug_ocimem_master #(
        .ADDR_W (10),
        .TIMEOUT(4)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_a),
        .take_no_action_ocimem_a(take_no),
        .take_action_ocimem_b   (take_b),
        .avm                    (bus),
        .MonDReg                (mon),
        .monitor_ready          (ready),
        .monitor_error          (error),
        .cmd_overrun            (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_addr(input logic [9:0] a, input logic rd, input logic clr);
        logic [37:0] v;
        v = '0;
        v[11:2] = a;
        v[34] = rd;
        v[35] = clr;
        return v;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    // Read and write requests must never overlap.
    always @(negedge clk) begin
        if (bus.avm_read && bus.avm_write) begin
            check_eq("rw_exclusive", 1, 0);
        end
    end

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_a = 1'b0;
        take_no = 1'b0;
        take_b = 1'b0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = '0;
        tick();
        tick();
        check_eq("rst_ready", ready, 1);
        check_eq("rst_mon", mon, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_read", bus.avm_read, 0);
        check_eq("rst_write", bus.avm_write, 0);
        check_eq("rst_addr", bus.avm_address, 0);
        check_eq("rst_be", bus.avm_byteenable, 4'hF);
        reset = 1'b0;
        tick();

        // Address load only
        jdo = jdo_addr(10'h005, 1'b0, 1'b0);
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        check_eq("lda_addr", bus.avm_address, 12'h014);
        check_eq("lda_read", bus.avm_read, 0);
        check_eq("lda_ready", ready, 1);
        tick();
        check_eq("lda_idle_read", bus.avm_read, 0);

        // Zero-wait write
        jdo = jdo_data(32'hCAFEF00D);
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        check_eq("wr_req", bus.avm_write, 1);
        check_eq("wr_addr", bus.avm_address, 12'h014);
        check_eq("wr_data", bus.avm_writedata, 32'hCAFEF00D);
        check_eq("wr_busy", ready, 0);
        tick();
        check_eq("wr_done_req", bus.avm_write, 0);
        check_eq("wr_done_ready", ready, 1);
        check_eq("wr_done_mon", mon, 32'hCAFEF00D);
        check_eq("wr_done_addr", bus.avm_address, 12'h018);

        // Read with 3 stall cycles
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata = 32'h12345678;
        take_no = 1'b1;
        tick();
        take_no = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("rd_stall_req", bus.avm_read, 1);
            check_eq("rd_stall_addr", bus.avm_address, 12'h018);
            check_eq("rd_stall_ready", ready, 0);
            tick();
        end
        bus.avm_waitrequest = 1'b0;
        check_eq("rd_last_req", bus.avm_read, 1);
        tick();
        check_eq("rd_done_req", bus.avm_read, 0);
        check_eq("rd_done_mon", mon, 32'h12345678);
        check_eq("rd_done_ready", ready, 1);
        check_eq("rd_done_addr", bus.avm_address, 12'h01C);

        // Load 3FF with read, then wrap
        jdo = jdo_addr(10'h3FF, 1'b1, 1'b0);
        bus.avm_readdata = 32'hAAAA5555;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        check_eq("wrap_req", bus.avm_read, 1);
        check_eq("wrap_addr", bus.avm_address, 12'hFFC);
        tick();
        check_eq("wrap_mon", mon, 32'hAAAA5555);
        check_eq("wrap_addr0", bus.avm_address, 12'h000);
        take_no = 1'b1;
        tick();
        take_no = 1'b0;
        check_eq("wrap_next_req", bus.avm_read, 1);
        check_eq("wrap_next_addr", bus.avm_address, 12'h000);
        tick();
        check_eq("wrap_next_done", bus.avm_address, 12'h004);

        // Timeout after 4 stall cycles
        bus.avm_waitrequest = 1'b1;
        take_no = 1'b1;
        tick();
        take_no = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("to_stall_req", bus.avm_read, 1);
            tick();
        end
        check_eq("to_req", bus.avm_read, 0);
        check_eq("to_error", error, 1);
        check_eq("to_mon", mon, 0);
        check_eq("to_ready", ready, 1);
        check_eq("to_addr", bus.avm_address, 12'h004);
        bus.avm_waitrequest = 1'b0;
        jdo = jdo_addr(10'h001, 1'b0, 1'b1);
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        check_eq("clr_error", error, 0);

        // Overrun during an in-flight read
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata = 32'h55AA33CC;
        take_no = 1'b1;
        tick();
        take_no = 1'b0;
        jdo = jdo_data(32'hDEADBEEF);
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        check_eq("ovr_flag", overrun, 1);
        check_eq("ovr_read", bus.avm_read, 1);
        check_eq("ovr_write", bus.avm_write, 0);
        bus.avm_waitrequest = 1'b0;
        tick();
        check_eq("ovr_mon", mon, 32'h55AA33CC);
        check_eq("ovr_ready", ready, 1);
        check_eq("ovr_addr", bus.avm_address, 12'h008);

        // Same-cycle a + b: only the address load (which also clears overrun)
        jdo = jdo_addr(10'h010, 1'b0, 1'b1);
        take_a = 1'b1;
        take_b = 1'b1;
        tick();
        take_a = 1'b0;
        take_b = 1'b0;
        check_eq("prio_write", bus.avm_write, 0);
        check_eq("prio_read", bus.avm_read, 0);
        check_eq("prio_addr", bus.avm_address, 12'h040);
        check_eq("prio_overrun", overrun, 0);
        check_eq("prio_ready", ready, 1);

        // Reset mid-write
        bus.avm_waitrequest = 1'b1;
        jdo = jdo_data(32'h00000001);
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        check_eq("rstw_req", bus.avm_write, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstw_write", bus.avm_write, 0);
        check_eq("rstw_ready", ready, 1);
        tick();
        reset = 1'b0;
        check_eq("rstw_addr", bus.avm_address, 0);
        check_eq("rstw_mon", mon, 0);
        bus.avm_waitrequest = 1'b0;
        tick();
        check_eq("rstw_idle", bus.avm_write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_ocimem_master.md
Name: debug_ocimem_master

Overview:
- Consumes the decoded JTAG debug commands (`jdo`, `take_action_ocimem_*`) from the debug-slave sysclk stage.
- Executes them as single-word Avalon-MM master transfers into CPU-visible memory.
- Returns results through `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into the debug-slave capture path.
- Auto-increments the word address so the host can stream reads and writes.

Parameters:
- ADDR_W, 10, word-address width; the byte address is ADDR_W+2 bits.
- TIMEOUT, 255, maximum cycles of waitrequest tolerated before a transfer aborts (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  command payload; valid in the cycle a take_* strobe is high.
- take_action_ocimem_a  in  1  load address; optional read.
- take_no_action_ocimem_a  in  1  read at current address, then increment.
- take_action_ocimem_b  in  1  write `jdo[34:3]` at current address, then increment.
- avm_address  out  ADDR_W+2  byte address; bits [1:0] always 0.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  always 4'hF.
- avm_readdata  in  32  read data; valid when avm_read && !avm_waitrequest.
- avm_waitrequest  in  1  slave stall.
- MonDReg  out  32  last read data, or last write data.
- monitor_ready  out  1  1 = idle; last command complete.
- monitor_error  out  1  sticky; the last transfer timed out.
- cmd_overrun  out  1  sticky; a command arrived while busy.

Behaviour:
- Reset values (asynchronous, active-high):
  - state = IDLE, addr = 0, avm_read = 0, avm_write = 0, avm_writedata = 0.
  - MonDReg = 0, monitor_ready = 1, monitor_error = 0, cmd_overrun = 0, timeout counter = 0.
- Strobe priority when several strobes are high in the same cycle: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority strobes are ignored without setting cmd_overrun.
- `take_action_ocimem_a` in IDLE:
  - addr <= `jdo[ADDR_W+1:2]`.
  - If `jdo[35]` = 1: clear monitor_error and cmd_overrun.
  - If `jdo[34]` = 1: start a read at the new address, exactly as `take_no_action_ocimem_a`.
  - Otherwise: remain IDLE, monitor_ready stays 1.
- Accept cycle for a read or write command in IDLE:
  - monitor_ready <= 0, monitor_error <= 0, timeout counter <= 0.
  - Read: avm_read <= 1. Write: avm_write <= 1, avm_writedata <= `jdo[34:3]`.
  - Bus signals are registered; the request is asserted from the cycle after the strobe.
- State machine IDLE -> RD or WR -> IDLE:
  - RD/WR hold avm_address, avm_read/avm_write and avm_writedata stable while avm_waitrequest = 1.
- Completion, on the first cycle the request is high and avm_waitrequest = 0:
  - Read: MonDReg <= avm_readdata.
  - Write: MonDReg <= the written data.
  - Deassert the request; addr <= addr + 1, wrapping modulo 2^ADDR_W (all-ones -> 0).
  - monitor_ready <= 1 and state <= IDLE in the same edge.
  - Minimum latency from strobe to monitor_ready = 1 is 2 cycles.
- Timeout:
  - The counter increments on each waitrequest = 1 cycle while in RD/WR.
  - When it reaches TIMEOUT with waitrequest still 1: deassert the request, MonDReg <= 0, monitor_error <= 1, monitor_ready <= 1, return to IDLE.
  - addr is NOT incremented on timeout.
- Any strobe while not IDLE (including `take_action_ocimem_a`) is dropped and sets cmd_overrun <= 1. The in-flight transfer is unaffected.
- Reset asserted mid-transfer: bus requests drop immediately (asynchronously); all state returns to reset values; no completion is reported.
- avm_read and avm_write are never both 1.

Test Plan:
- Reset, then `take_action_ocimem_a` with `jdo[ADDR_W+1:2]` = 10'h005 and `jdo[34]` = 0 -> addr = 5, no bus activity, monitor_ready stays 1.
- `take_action_ocimem_b` with `jdo[34:3]` = 32'hCAFEF00D, waitrequest low -> avm_write for one cycle at avm_address 12'h014, MonDReg = CAFEF00D, monitor_ready = 1 two cycles after the strobe, addr = 6.
- `take_no_action_ocimem_a` with waitrequest high for 3 cycles, readdata = 32'h12345678 -> avm_read held 4 cycles with stable address 12'h018, then MonDReg = 12345678, addr = 7.
- Load addr 10'h3FF, then read -> completes and addr wraps to 0; the next read shows avm_address = 0.
- TIMEOUT = 4 with waitrequest stuck high -> request drops after 4 stall cycles, monitor_error = 1, MonDReg = 0, addr unchanged. A subsequent `take_action_ocimem_a` with `jdo[35]` = 1 clears monitor_error.
- Strobe `take_action_ocimem_b` during an in-flight read -> cmd_overrun = 1 and the read completes normally. Same-cycle `take_action_ocimem_a` + `take_action_ocimem_b` -> only the address load occurs. Reset pulsed while in WR -> avm_write = 0 immediately and monitor_ready = 1.
